clk_div_prog: RTL and testbench

Programmable single-channel clock-enable/divided-clock generator; the parametrised successor to the fixed div-2/4/8, div-6 and 1-in-5 dividers.
Divisor N is loadable at runtime and takes effect glitch-free at the next period boundary.

---
 rtl/clk_div_prog_if.sv | 24 ++
 rtl/clk_div_prog.sv | 78 +++++++
 tb/tb_clk_div_prog.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/clk_div_prog_if.sv
// Control/status bundle for the programmable clock divider: divisor load
// request from the master side, divided clock and live settings back.
interface clk_div_prog_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             div_load;
    logic [CNT_W-1:0] div_val;
    logic             mode_in;
    logic             clk_out;
    logic             tick;
    logic [CNT_W-1:0] div_active;
    logic             mode_active;

    modport master (
        output en, div_load, div_val, mode_in,
        input  clk_out, tick, div_active, mode_active
    );

    modport slave (
        input  en, div_load, div_val, mode_in,
        output clk_out, tick, div_active, mode_active
    );
endinterface

// File: rtl/clk_div_prog.sv
// Programmable divided-clock / clock-enable generator with square or
// one-of-N duty; new divisors take effect only at a period boundary.
module clk_div_prog #(
    parameter int CNT_W        = 8,
    parameter int DEFAULT_DIV  = 6,
    parameter int DEFAULT_MODE = 0
) (
    input  logic          clk,
    input  logic          reset,
    clk_div_prog_if.slave bus
);
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] div_active_reg;
    logic             mode_active_reg;
    logic [CNT_W-1:0] pend_div_reg;
    logic             pend_mode_reg;
    logic             pend_valid_reg;
    logic             clk_out_reg;
    logic             tick_reg;

    logic [CNT_W-1:0] last_cnt;
    logic [CNT_W-1:0] half_cnt;
    logic [CNT_W-1:0] load_div;
    logic             wrap;

    always_comb begin
        last_cnt = div_active_reg - CNT_W'(1);
        half_cnt = mode_active_reg ? CNT_W'(1) : (div_active_reg >> 1);
        load_div = (bus.div_val < CNT_W'(2)) ? CNT_W'(2) : bus.div_val;
        wrap     = bus.en && (cnt_reg == last_cnt);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_reg         <= '0;
            div_active_reg  <= CNT_W'(DEFAULT_DIV);
            mode_active_reg <= 1'(DEFAULT_MODE);
            pend_div_reg    <= CNT_W'(DEFAULT_DIV);
            pend_mode_reg   <= 1'(DEFAULT_MODE);
            pend_valid_reg  <= 1'b0;
            clk_out_reg     <= 1'b0;
            tick_reg        <= 1'b0;
        end else begin
            tick_reg <= wrap;

            // A load landing on a wrap edge bypasses the pending slot.
            if (bus.div_load && !wrap) begin
                pend_div_reg   <= load_div;
                pend_mode_reg  <= bus.mode_in;
                pend_valid_reg <= 1'b1;
            end

            if (wrap) begin
                cnt_reg     <= '0;
                clk_out_reg <= 1'b1;
                if (bus.div_load) begin
                    div_active_reg  <= load_div;
                    mode_active_reg <= bus.mode_in;
                    pend_valid_reg  <= 1'b0;
                end else if (pend_valid_reg) begin
                    div_active_reg  <= pend_div_reg;
                    mode_active_reg <= pend_mode_reg;
                    pend_valid_reg  <= 1'b0;
                end
            end else if (bus.en) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
                if (cnt_reg == half_cnt - CNT_W'(1)) begin
                    clk_out_reg <= 1'b0;
                end
            end
        end
    end

    assign bus.clk_out     = clk_out_reg;
    assign bus.tick        = tick_reg;
    assign bus.div_active  = div_active_reg;
    assign bus.mode_active = mode_active_reg;
endmodule

// File: tb/tb_clk_div_prog.sv
// Randomised and directed bench for clk_div_prog against a period/phase
// reference model.
module tb_clk_div_prog;
    localparam int CNT_W        = 8;
    localparam int DEFAULT_DIV  = 6;
    localparam int DEFAULT_MODE = 0;

    logic clk;
    logic reset;

    clk_div_prog_if #(.CNT_W(CNT_W)) bus ();

    clk_div_prog #(
        .CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV), .DEFAULT_MODE(DEFAULT_MODE)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: position within current period, period length, duty mode,
    // whether the first (all-low) period after reset is still running.
    int pos;
    int n_m;
    int m_m;
    int first_m;
    int pv_m;
    int pd_m;
    int pm_m;
    int tick_m;
    int cyc = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int clamp(input int v);
        return (v < 2) ? 2 : v;
    endfunction

    function automatic int high_len(input int n, input int m);
        return m ? 1 : n / 2;
    endfunction

    function automatic int exp_clk_out();
        if (first_m) return 0;
        return (pos < high_len(n_m, m_m)) ? 1 : 0;
    endfunction

    task automatic model_edge(input int r, input int e, input int l, input int v, input int md);
        int wrapped;
        wrapped = 0;
        if (!r) begin
            pos = 0; n_m = DEFAULT_DIV; m_m = DEFAULT_MODE;
            first_m = 1; pv_m = 0; tick_m = 0;
        end else begin
            if (e) begin
                wrapped = (pos == n_m - 1);
                tick_m  = wrapped;
                if (wrapped) begin
                    pos = 0;
                    first_m = 0;
                    if (l) begin
                        n_m = clamp(v); m_m = md; pv_m = 0;
                    end else if (pv_m) begin
                        n_m = pd_m; m_m = pm_m; pv_m = 0;
                    end
                end else begin
                    pos++;
                end
            end else begin
                tick_m = 0;
            end
            if (l && !wrapped) begin
                pd_m = clamp(v); pm_m = md; pv_m = 1;
            end
        end
    endtask

    // Called at a negedge: drive, take one posedge, check at the next negedge.
    task automatic cycle(input int r, input int e, input int l, input int v, input int md);
        reset        = r[0];
        bus.en       = e[0];
        bus.div_load = l[0];
        bus.div_val  = v[CNT_W-1:0];
        bus.mode_in  = md[0];
        @(posedge clk);
        model_edge(r, e, l, v, md);
        cyc++;
        @(negedge clk);
        check("clk_out", int'(bus.clk_out), exp_clk_out());
        check("tick", int'(bus.tick), tick_m);
        check("div_active", int'(bus.div_active), n_m);
        check("mode_active", int'(bus.mode_active), m_m);
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) cycle(1, 1, 0, 0, 0);
    endtask

    // Advance until the next enabled edge would be a wrap edge.
    task automatic run_to_last(input string tag);
        int budget;
        budget = 300;
        while (pos != n_m - 1 && budget > 0) begin
            cycle(1, 1, 0, 0, 0);
            budget--;
        end
        check({tag, "_reached"}, int'(budget > 0), 1);
    endtask

    int high_cnt;

    initial begin
        reset = 1'b0; bus.en = 1'b0; bus.div_load = 1'b0;
        bus.div_val = '0; bus.mode_in = 1'b0;
        pos = 0; n_m = DEFAULT_DIV; m_m = DEFAULT_MODE; first_m = 1;
        pv_m = 0; pd_m = DEFAULT_DIV; pm_m = DEFAULT_MODE; tick_m = 0;
        @(negedge clk);

        // Reset, then default N=6 square.
        cycle(0, 1, 1, 9, 1);
        cycle(0, 1, 0, 0, 0);
        run(20);

        // Mid-period load 5 / one-of-N.
        run(2);
        cycle(1, 1, 1, 5, 1);
        run(16);
        check("div5_applied", int'(bus.div_active), 5);

        // Clamped divisors.
        cycle(1, 1, 1, 0, 0);
        run(10);
        check("clamp0", int'(bus.div_active), 2);
        cycle(1, 1, 1, 1, 0);
        run(10);
        check("clamp1", int'(bus.div_active), 2);

        // Enable gap during a high phase at N=6.
        cycle(1, 1, 1, 6, 0);
        run(4);
        run_to_last("to_wrap6");
        cycle(1, 1, 0, 0, 0);
        high_cnt = 1;
        for (int i = 0; i < 4; i++) begin
            cycle(1, 0, 0, 0, 0);
            if (bus.clk_out) high_cnt++;
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1, 1, 0, 0, 0);
            if (bus.clk_out) high_cnt++;
        end
        check("gap_high_len", high_cnt, 7);
        run(8);

        // Load exactly on a wrap edge.
        run_to_last("to_wrap7");
        cycle(1, 1, 1, 7, 0);
        check("wrap_load7", int'(bus.div_active), 7);
        run(21);

        // Pending load discarded by reset.
        cycle(1, 1, 1, 6, 0);
        run(10);
        run(2);
        cycle(1, 1, 1, 9, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        run(30);
        check("rst_discard", int'(bus.div_active), 6);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            int r, e, l, v, md;
            r  = ($urandom_range(0, 99) < 2) ? 0 : 1;
            e  = ($urandom_range(0, 7) != 0) ? 1 : 0;
            l  = ($urandom_range(0, 15) == 0) ? 1 : 0;
            v  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
            md = $urandom_range(0, 1);
            cycle(r, e, l, v, md);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
